// File: rtl/fft_pkg.sv
// Shared fixed-point definitions for the FFT/IFFT datapath: word format,
// Q-format constants, complex word type and the radix-16 twiddle table.
package fft_pkg;

  localparam int DATA_WIDTH = 21;
  localparam int FRAC_BITS  = 15;

  localparam int Q_ONE     = 1 << FRAC_BITS;
  localparam int Q_HALF    = 1 << (FRAC_BITS - 1);
  localparam int Q_QUARTER = 1 << (FRAC_BITS - 2);

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] re;
    logic signed [DATA_WIDTH-1:0] im;
  } cplx_t;

  // Forward twiddles W16^k = exp(-j*2*pi*k/16), k = 0..3, in Q(FRAC_BITS).
  localparam int W16_RE [4] = '{32768, 30274, 23170, 12540};
  localparam int W16_IM [4] = '{0, -12540, -23170, -30274};

endpackage

// File: rtl/cmul_conj.sv
// Combinational full-precision complex multiply d * conj(w).
// Product terms are 2*DW+1 bits, the re/im sums 2*DW+2 bits.
module cmul_conj #(
  parameter int DW = 21
) (
  input  logic signed [DW:0]     d_re_i,
  input  logic signed [DW:0]     d_im_i,
  input  logic signed [DW-1:0]   w_re_i,
  input  logic signed [DW-1:0]   w_im_i,
  output logic signed [2*DW+1:0] p_re_o,
  output logic signed [2*DW+1:0] p_im_o
);

  localparam int MW = 2 * DW + 1;

  logic signed [MW-1:0] dre_x, dim_x, wre_x, wim_x;
  logic signed [MW-1:0] rr, ii, ir, ri;

  always_comb begin
    // Operands are widened to the product width so the multiply is exact.
    dre_x  = {{(MW-DW-1){d_re_i[DW]}}, d_re_i};
    dim_x  = {{(MW-DW-1){d_im_i[DW]}}, d_im_i};
    wre_x  = {{(MW-DW){w_re_i[DW-1]}}, w_re_i};
    wim_x  = {{(MW-DW){w_im_i[DW-1]}}, w_im_i};
    rr     = dre_x * wre_x;
    ii     = dim_x * wim_x;
    ir     = dim_x * wre_x;
    ri     = dre_x * wim_x;
    p_re_o = {rr[MW-1], rr} + {ii[MW-1], ii};
    p_im_o = {ir[MW-1], ir} - {ri[MW-1], ri};
  end

endmodule

// File: rtl/ibutterfly_pipe.sv
// 3-stage radix-2 inverse butterfly: A=(A'+B')/2, B=conj(W)*(A'-B')/2.
// Define IBFLY_ROUND_EN for round-half-up on both output shifts (default: floor).
module ibutterfly_pipe #(
  parameter int DATA_WIDTH = fft_pkg::DATA_WIDTH,
  parameter int FRAC_BITS  = fft_pkg::FRAC_BITS
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic signed [DATA_WIDTH-1:0] twid_re_i,
  input  logic signed [DATA_WIDTH-1:0] twid_im_i,
  input  logic signed [DATA_WIDTH-1:0] a_re_i,
  input  logic signed [DATA_WIDTH-1:0] a_im_i,
  input  logic signed [DATA_WIDTH-1:0] b_re_i,
  input  logic signed [DATA_WIDTH-1:0] b_im_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic signed [DATA_WIDTH-1:0] a_re_o,
  output logic signed [DATA_WIDTH-1:0] a_im_o,
  output logic signed [DATA_WIDTH-1:0] b_re_o,
  output logic signed [DATA_WIDTH-1:0] b_im_o
);

  localparam int DW = DATA_WIDTH;
  localparam int SW = DW + 1;
  localparam int PW = 2 * DW + 2;

`ifdef IBFLY_ROUND_EN
  localparam logic signed [SW:0]   RND_A = {{SW{1'b0}}, 1'b1};
  localparam logic signed [PW-1:0] RND_B = {{(PW-1){1'b0}}, 1'b1} << FRAC_BITS;
`else
  localparam logic signed [SW:0]   RND_A = '0;
  localparam logic signed [PW-1:0] RND_B = '0;
`endif

  // Handshake: a word moves into a stage when that stage is empty or its
  // downstream neighbour is moving too; in_ready_o is the end of that chain.
  logic en1, en2, en3;
  logic v1_q, v2_q, v3_q;

  logic signed [SW-1:0] sum_re_d, sum_im_d, diff_re_d, diff_im_d;
  logic signed [SW-1:0] sum_re_q, sum_im_q, diff_re_q, diff_im_q;
  logic signed [DW-1:0] twr_q, twi_q;

  logic signed [SW-1:0] sum2_re_q, sum2_im_q;
  logic signed [PW-1:0] p_re_d, p_im_d, p_re_q, p_im_q;

  logic signed [DW-1:0] a_re_d, a_im_d, b_re_d, b_im_d;
  logic signed [DW-1:0] a_re_q, a_im_q, b_re_q, b_im_q;

  cmul_conj #(.DW(DW)) u_cmul (
    .d_re_i (diff_re_q),
    .d_im_i (diff_im_q),
    .w_re_i (twr_q),
    .w_im_i (twi_q),
    .p_re_o (p_re_d),
    .p_im_o (p_im_d)
  );

  always_comb begin
    en3       = !v3_q || out_ready_i;
    en2       = !v2_q || en3;
    en1       = !v1_q || en2;
    sum_re_d  = {a_re_i[DW-1], a_re_i} + {b_re_i[DW-1], b_re_i};
    sum_im_d  = {a_im_i[DW-1], a_im_i} + {b_im_i[DW-1], b_im_i};
    diff_re_d = {a_re_i[DW-1], a_re_i} - {b_re_i[DW-1], b_re_i};
    diff_im_d = {a_im_i[DW-1], a_im_i} - {b_im_i[DW-1], b_im_i};
    // The /2 of the inverse is folded into the shifts; results wrap to DW bits.
    a_re_d    = DW'(($signed({sum2_re_q[SW-1], sum2_re_q}) + RND_A) >>> 1);
    a_im_d    = DW'(($signed({sum2_im_q[SW-1], sum2_im_q}) + RND_A) >>> 1);
    b_re_d    = DW'((p_re_q + RND_B) >>> (FRAC_BITS + 1));
    b_im_d    = DW'((p_im_q + RND_B) >>> (FRAC_BITS + 1));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      sum_re_q  <= '0;
      sum_im_q  <= '0;
      diff_re_q <= '0;
      diff_im_q <= '0;
      twr_q     <= '0;
      twi_q     <= '0;
      sum2_re_q <= '0;
      sum2_im_q <= '0;
      p_re_q    <= '0;
      p_im_q    <= '0;
      a_re_q    <= '0;
      a_im_q    <= '0;
      b_re_q    <= '0;
      b_im_q    <= '0;
    end else begin
      if (en1) begin
        v1_q <= in_valid_i;
        if (in_valid_i) begin
          sum_re_q  <= sum_re_d;
          sum_im_q  <= sum_im_d;
          diff_re_q <= diff_re_d;
          diff_im_q <= diff_im_d;
          twr_q     <= twid_re_i;
          twi_q     <= twid_im_i;
        end
      end
      if (en2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          sum2_re_q <= sum_re_q;
          sum2_im_q <= sum_im_q;
          p_re_q    <= p_re_d;
          p_im_q    <= p_im_d;
        end
      end
      if (en3) begin
        v3_q <= v2_q;
        if (v2_q) begin
          a_re_q <= a_re_d;
          a_im_q <= a_im_d;
          b_re_q <= b_re_d;
          b_im_q <= b_im_d;
        end
      end
    end
  end

  assign in_ready_o  = en1;
  assign out_valid_o = v3_q;
  assign a_re_o      = a_re_q;
  assign a_im_o      = a_im_q;
  assign b_re_o      = b_re_q;
  assign b_im_o      = b_im_q;

endmodule

// File: tb/tb_ibutterfly_pipe.sv
// Self-checking bench for ibutterfly_pipe: scoreboard of expected pairs,
// directed vectors, latency, backpressure, async reset and random round trip.
module tb_ibutterfly_pipe;
  import fft_pkg::*;

  localparam int DW = DATA_WIDTH;
  localparam int FB = FRAC_BITS;
  localparam int PW = 4 * DW;
  localparam logic signed [DW-1:0] TW_RE = 21'sd30274;
  localparam logic signed [DW-1:0] TW_IM = -21'sd12540;

  logic                 clk, rst;
  logic                 in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic signed [DW-1:0] twid_re_i, twid_im_i;
  logic signed [DW-1:0] a_re_i, a_im_i, b_re_i, b_im_i;
  logic signed [DW-1:0] a_re_o, a_im_o, b_re_o, b_im_o;

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] orig_q[$];
  logic [PW-1:0] got;
  logic          got_v;
  int            checks, failures;

  ibutterfly_pipe #(.DATA_WIDTH(DW), .FRAC_BITS(FB)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .twid_re_i   (twid_re_i),
    .twid_im_i   (twid_im_i),
    .a_re_i      (a_re_i),
    .a_im_i      (a_im_i),
    .b_re_i      (b_re_i),
    .b_im_i      (b_im_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .a_re_o      (a_re_o),
    .a_im_o      (a_im_o),
    .b_re_o      (b_re_o),
    .b_im_o      (b_im_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [PW-1:0] model(input longint ar, ai, br, bi);
    longint sr, si, pr, pi, dr, di;
    sr = ar + br;
    si = ai + bi;
    dr = ar - br;
    di = ai - bi;
    pr = dr * longint'(TW_RE) + di * longint'(TW_IM);
    pi = di * longint'(TW_RE) - dr * longint'(TW_IM);
`ifdef IBFLY_ROUND_EN
    sr = sr + 1;
    si = si + 1;
    pr = pr + (longint'(1) << FB);
    pi = pi + (longint'(1) << FB);
`endif
    return {DW'(sr >>> 1), DW'(si >>> 1), DW'(pr >>> (FB + 1)), DW'(pi >>> (FB + 1))};
  endfunction

  function automatic longint field(input logic [PW-1:0] v, input int idx);
    logic signed [DW-1:0] f;
    f = v[PW-1-idx*DW -: DW];
    return longint'(f);
  endfunction

  // ---------------- driver + scoreboard ----------------
  task automatic drive_cycle(input logic iv, input logic ordy,
                             input logic signed [DW-1:0] ar, ai, br, bi,
                             input logic [PW-1:0] exp_v);
    logic [PW-1:0] e;
    logic          rdy_exp;
    @(negedge clk);
    in_valid_i  = iv;
    out_ready_i = ordy;
    twid_re_i   = TW_RE;
    twid_im_i   = TW_IM;
    a_re_i = ar; a_im_i = ai; b_re_i = br; b_im_i = bi;
    #1;
    got_v   = 1'b0;
    rdy_exp = !(exp_q.size() == 3 && !ordy);
    checks++;
    if (in_ready_o !== rdy_exp) begin
      failures++;
      $display("FAIL in_ready got=%0b required=%0b inflight=%0d", in_ready_o, rdy_exp, exp_q.size());
    end
    if (out_valid_o && out_ready_i) begin
      got   = {a_re_o, a_im_o, b_re_o, b_im_o};
      got_v = 1'b1;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got=%h required=no output", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL sb_data got=%h required=%h", got, e);
        end
      end
    end
    if (in_valid_i && in_ready_o) exp_q.push_back(exp_v);
  endtask

  task automatic idle_cycle(input logic ordy);
    drive_cycle(1'b0, ordy, '0, '0, '0, '0, '0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    twid_re_i = TW_RE; twid_im_i = TW_IM;
    a_re_i = '0; a_im_i = '0; b_re_i = '0; b_im_i = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid_o !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%0b required=0", out_valid_o);
    end
    checks++;
    if ({a_re_o, a_im_o, b_re_o, b_im_o} !== '0) begin
      failures++; $display("FAIL reset_data got=%h required=0", {a_re_o, a_im_o, b_re_o, b_im_o});
    end
    checks++;
    if (in_ready_o !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%0b required=1", in_ready_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_vectors;
    logic [PW-1:0] e1, e2;
`ifdef IBFLY_ROUND_EN
    e1 = {21'sd12288, 21'sd4096, 21'sd5352, -21'sd2217};
    e2 = {21'sd16384, 21'sd8192, 21'sd18272, -21'sd1298};
`else
    e1 = {21'sd12288, 21'sd4096, 21'sd5351, -21'sd2217};
    e2 = {21'sd16384, 21'sd8192, 21'sd18272, -21'sd1299};
`endif
    drive_cycle(1'b1, 1'b1, 21'sd16384, 21'sd0, 21'sd8192, 21'sd8192, e1);
    drive_cycle(1'b1, 1'b1, 21'sd32768, 21'sd0, 21'sd0, 21'sd16384, e2);
    repeat (5) idle_cycle(1'b1);
  endtask

  task automatic test_latency;
    logic signed [DW-1:0] ar, ai, br, bi;
    for (int i = 0; i < 12; i++) begin
      if (i < 6) begin
        ar = DW'(longint'($urandom_range(0, 65534)) - 32767);
        ai = DW'(longint'($urandom_range(0, 65534)) - 32767);
        br = DW'(longint'($urandom_range(0, 65534)) - 32767);
        bi = DW'(longint'($urandom_range(0, 65534)) - 32767);
        drive_cycle(1'b1, 1'b1, ar, ai, br, bi, model(ar, ai, br, bi));
      end else begin
        idle_cycle(1'b1);
      end
      checks++;
      if (out_valid_o !== (i >= 3 && i < 9)) begin
        failures++;
        $display("FAIL latency cycle=%0d got=%0b required=%0b", i, out_valid_o, (i >= 3 && i < 9));
      end
    end
  endtask

  task automatic test_backpressure;
    logic [7:0]           lfsr;
    logic signed [DW-1:0] ar, ai, br, bi;
    logic [PW-1:0]        held;
    logic                 stalled, ordy;
    int                   sent, outs, guard;
    lfsr = 8'hA5; sent = 0; outs = 0; guard = 0; stalled = 1'b0; held = '0;
    ar = '0; ai = '0; br = '0; bi = '0;
    while ((sent < 8 || exp_q.size() != 0) && guard < 200) begin
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      ordy = lfsr[0];
      if (sent < 8) begin
        ar = DW'(sent * 1000 + 17); ai = DW'(-sent * 700);
        br = DW'(sent * 333);       bi = DW'(5000 - sent * 1234);
        drive_cycle(1'b1, ordy, ar, ai, br, bi, model(ar, ai, br, bi));
        if (in_ready_o) sent++;
      end else begin
        idle_cycle(ordy);
      end
      if (got_v) outs++;
      if (stalled) begin
        checks++;
        if (out_valid_o !== 1'b1 || {a_re_o, a_im_o, b_re_o, b_im_o} !== held) begin
          failures++;
          $display("FAIL stall_hold got=%0b/%h required=1/%h", out_valid_o,
                   {a_re_o, a_im_o, b_re_o, b_im_o}, held);
        end
      end
      stalled = out_valid_o && !out_ready_i;
      held    = {a_re_o, a_im_o, b_re_o, b_im_o};
      guard++;
    end
    checks++;
    if (outs != 8) begin
      failures++; $display("FAIL bp_count got=%0d required=8 (cycles=%0d)", outs, guard);
    end
  endtask

  task automatic test_reset_midflight;
    drive_cycle(1'b1, 1'b0, 21'sd1111, 21'sd2222, 21'sd3333, 21'sd4444, model(1111, 2222, 3333, 4444));
    drive_cycle(1'b1, 1'b0, 21'sd5555, 21'sd6666, 21'sd7777, 21'sd8888, model(5555, 6666, 7777, 8888));
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    checks++;
    if (out_valid_o !== 1'b1) begin
      failures++; $display("FAIL pre_reset_valid got=%0b required=1", out_valid_o);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || {a_re_o, a_im_o, b_re_o, b_im_o} !== '0) begin
      failures++;
      $display("FAIL async_reset got=%0b/%h required=0/0", out_valid_o, {a_re_o, a_im_o, b_re_o, b_im_o});
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 0) drive_cycle(1'b1, 1'b1, -21'sd900, 21'sd400, 21'sd1200, -21'sd50, model(-900, 400, 1200, -50));
      else        idle_cycle(1'b1);
      checks++;
      if (out_valid_o !== (i == 3)) begin
        failures++;
        $display("FAIL post_reset_latency cycle=%0d got=%0b required=%0b", i, out_valid_o, (i == 3));
      end
    end
  endtask

  task automatic test_round_trip;
    longint ar, ai, br, bi, wbr, wbi, msq, ref_v, d;
    logic [PW-1:0] o;
    int sent, done, guard;
    // |W|^2 of the quantised twiddle is not exactly one; B is scaled by it.
    msq = longint'(TW_RE) * longint'(TW_RE) + longint'(TW_IM) * longint'(TW_IM);
    sent = 0; done = 0; guard = 0;
    ar = 0; ai = 0; br = 0; bi = 0; wbr = 0; wbi = 0;
    while (done < 1000 && guard < 5000) begin
      if (sent < 1000 && (orig_q.size() == 0 || ar != field(orig_q[$], 0) || sent == 0 ||
                          orig_q.size() < sent - done)) begin
      end
      if (sent < 1000) begin
        if (orig_q.size() == sent - done) begin
          ar = longint'($urandom_range(0, 262142)) - 131071;
          ai = longint'($urandom_range(0, 262142)) - 131071;
          br = longint'($urandom_range(0, 262142)) - 131071;
          bi = longint'($urandom_range(0, 262142)) - 131071;
          wbr = (br * longint'(TW_RE) - bi * longint'(TW_IM) + (longint'(1) << (FB - 1))) >>> FB;
          wbi = (br * longint'(TW_IM) + bi * longint'(TW_RE) + (longint'(1) << (FB - 1))) >>> FB;
        end
        drive_cycle(1'b1, ($urandom_range(0, 3) != 0),
                    DW'(ar + wbr), DW'(ai + wbi), DW'(ar - wbr), DW'(ai - wbi),
                    model(ar + wbr, ai + wbi, ar - wbr, ai - wbi));
        if (in_ready_o) begin
          orig_q.push_back({DW'(ar), DW'(ai), DW'(br), DW'(bi)});
          sent++;
        end
      end else begin
        idle_cycle(($urandom_range(0, 3) != 0));
      end
      if (got_v && orig_q.size() != 0) begin
        o = orig_q.pop_front();
        done++;
        for (int k = 0; k < 4; k++) begin
          ref_v = (k < 2) ? field(o, k) : ((field(o, k) * msq + (longint'(1) << 29)) >>> 30);
          d = field(got, k) - ref_v;
          checks++;
          if (d > 2 || d < -2) begin
            failures++;
            $display("FAIL round_trip item=%0d comp=%0d got=%0d required=%0d+-2", done, k, field(got, k), ref_v);
          end
        end
      end
      guard++;
    end
    checks++;
    if (done != 1000) begin
      failures++; $display("FAIL round_trip_count got=%0d required=1000", done);
    end
  endtask

  initial begin
    checks = 0; failures = 0; got = '0; got_v = 1'b0;
    test_reset();
    test_vectors();
    test_latency();
    test_backpressure();
    test_reset_midflight();
    test_round_trip();
    repeat (6) idle_cycle(1'b1);
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL drain got=%0d left required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ibutterfly_pipe.md
Name: ibutterfly_pipe

Overview:
Pipelined radix-2 inverse butterfly. It undoes the forward DIT butterfly (A'=A+W·B, B'=A−W·B) and recovers A=(A'+B')/2 and B=conj(W)·(A'−B')/2.
- Sits in the IFFT/reconstruction datapath after the forward butterfly array.
- Uses the same Q(FRAC_BITS) fixed-point format and the same forward twiddle values; conjugation is done internally.
- Has valid/ready handshakes on both sides and a 3-stage register pipeline.

Parameters:
DATA_WIDTH, 21, signed width of every data and twiddle word (Q5.15 by default)
FRAC_BITS, 15, fractional bits of data and twiddle

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset; asynchronous, active-high
in_valid_i  input  1  input word pair valid
in_ready_o  output  1  block accepts input this cycle
twid_re_i  input  DATA_WIDTH  forward twiddle real part W_re (signed)
twid_im_i  input  DATA_WIDTH  forward twiddle imag part W_im (signed)
a_re_i, a_im_i  input  DATA_WIDTH each  A' (signed)
b_re_i, b_im_i  input  DATA_WIDTH each  B' (signed)
out_valid_o  output  1  output pair valid
out_ready_i  input  1  downstream accepts output
a_re_o, a_im_o  output  DATA_WIDTH each  recovered A
b_re_o, b_im_o  output  DATA_WIDTH each  recovered B

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is asynchronous and active-high.
- Reset values: all stage valids clear, out_valid_o=0, all data outputs=0. Reset mid-operation discards all in-flight words, with no partial output.
- Handshakes:
  - Transfer occurs on in_valid_i&&in_ready_o (input side) and on out_valid_o&&out_ready_i (output side).
  - Twiddle and data are sampled together at the input transfer.
- Stage enables:
  - en3 = !v3 | out_ready_i
  - en2 = !v2 | en3
  - en1 = !v1 | en2
  - in_ready_o = en1
  - The ready path is combinational. Bubbles collapse.
- Output stability: while out_valid_o=1 and out_ready_i=0, outputs hold stable.
- Latency and throughput: 3 cycles from input transfer to out_valid_o when unstalled. Throughput is 1 pair per cycle.
- S1 (register when en1; v1<=in_valid_i):
  - sum = A'+B' and diff = A'−B', each component DATA_WIDTH+1 bits signed.
  - Register the twiddle.
- S2 (register when en2; v2<=v1): full-precision products with conj(W)=(W_re, −W_im):
  - p_re = d_re·W_re + d_im·W_im
  - p_im = d_im·W_re − d_re·W_im
  - Each product is 2·DATA_WIDTH+1 bits; each sum is 2·DATA_WIDTH+2 bits.
  - Sum path is delayed unchanged.
- S3 (register when en3; v3<=v2):
  - a_o = sum >>> 1
  - b_o = p >>> (FRAC_BITS+1)
  - Shifts are arithmetic; the divide-by-2 is folded into the shift.
  - Truncate to DATA_WIDTH, wrapping. No overflow occurs for |W|≤1 and |A'|,|B'| < 2^(DATA_WIDTH−2).
- Simultaneous events: input accept and output drain in the same cycle are both honoured. A full pipeline with out_ready_i=1 passes 1 word per cycle.
- in_valid_i=0 injects a bubble: v1<=0 and the data registers may hold.

Optional Feature:
- Macro: IBFLY_ROUND_EN.
- Defined: round-half-up on both shifts. Add 1<<0 to sum before >>>1, and add 1<<FRAC_BITS to p before >>>(FRAC_BITS+1).
- Undefined: plain arithmetic-shift truncation (floor).
- Latency and widths are identical in both cases.

Decomposition:
- Shared package fft_pkg:
  - DATA_WIDTH and FRAC_BITS defaults
  - Q_ONE, Q_HALF and Q_QUARTER constants
  - a complex-word typedef (re/im of DATA_WIDTH)
  - W16 twiddle table constants
- Sub-module cmul_conj: combinational full-precision d·conj(W), instantiated once in S2.

Test Plan:
Twiddle for all rows is W16^1 (twid_re_i=30274, twid_im_i=−12540, sign-extended).
- Test 1: A'=(16384,0), B'=(8192,8192) -> a_o=(12288,4096), b_o=(5351,−2217) truncating; b_o=(5352,−2217) with IBFLY_ROUND_EN.
- Test 2: A'=(32768,0), B'=(0,16384) -> a_o=(16384,8192), b_o=(18272,−1299) truncating; b_o=(18272,−1298) with IBFLY_ROUND_EN.
- Round trip: 1000 random A,B with |re|,|im|<2^17 through the forward butterfly model, then this DUT -> recovers A,B within ±2 LSB.
- Backpressure: stream 8 pairs with out_ready_i toggling on an LFSR -> all 8 emerge in order, unchanged and stable while stalled; in_ready_o=0 only when v1..v3 are full and out_ready_i=0.
- Reset: assert rst_i asynchronously with 2 words in flight -> out_valid_o=0 immediately. After release, a new input appears after exactly 3 cycles and the old words never appear.
- Latency and throughput: continuous in_valid_i with out_ready_i=1 -> first out_valid_o 3 cycles after the first transfer, then one result per cycle.
